// File: rtl/debug_str_serializer.sv
// Streams a snapshot of a wide debug word out as ASCII hex digits, with a separator between digit groups.
// Define DISP_LOWERCASE_EN to emit hex letters a-f instead of A-F.
module debug_str_serializer #(
  parameter int          NIBBLES  = 32,
  parameter int          GROUP    = 8,
  parameter logic [7:0]  SEP_CHAR = 8'h20,
  parameter int          ADDR_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic [7:0]             char_data,
  output logic [ADDR_W-1:0]      char_addr
);

  localparam int DW    = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int GRP_W = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT  = CNT_W'(NIBBLES - 1);
  localparam logic [GRP_W-1:0] LAST_IN_GRP = GRP_W'(GROUP - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DW-1:0]      shreg;
  logic [CNT_W-1:0]   digit_cnt;
  logic [GRP_W-1:0]   grp_cnt;
  logic               sep_pending;
  logic               accept;
  logic               last_digit;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
`ifdef DISP_LOWERCASE_EN
    return 8'h57 + {4'h0, n};
`else
    return 8'h37 + {4'h0, n};
`endif
  endfunction

  assign accept     = (state == S_EMIT) && char_ready;
  assign last_digit = (digit_cnt == LAST_DIGIT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_EMIT;
      S_EMIT: if (accept && !sep_pending && last_digit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Snapshot on start; afterwards the top nibble of shreg is always the next digit to emit.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_addr   <= '0;
      sep_pending <= 1'b0;
    end else if (state == S_IDLE && start) begin
      shreg       <= data_in;
      digit_cnt   <= '0;
      grp_cnt     <= '0;
      char_addr   <= '0;
      sep_pending <= 1'b0;
    end else if (accept) begin
      char_addr <= char_addr + 1'b1;
      if (sep_pending) begin
        sep_pending <= 1'b0;
      end else begin
        shreg     <= shreg << 4;
        digit_cnt <= digit_cnt + 1'b1;
        if (grp_cnt == LAST_IN_GRP) begin
          grp_cnt     <= '0;
          sep_pending <= !last_digit;
        end else begin
          grp_cnt <= grp_cnt + 1'b1;
        end
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign char_valid = (state == S_EMIT);
  assign char_data  = !char_valid ? 8'h00 :
                      sep_pending ? SEP_CHAR : hex_ascii(shreg[DW-1 -: 4]);

endmodule

// File: tb/tb_debug_str_serializer.sv
// Scoreboard bench for debug_str_serializer: three instances (default, 8x2 with 2-bit address, 4x4).
module tb_debug_str_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_a, ready_a, busy_a, done_a, valid_a;
  logic [127:0] data_a;
  logic [7:0]   cd_a, ca_a;

  logic         start_b, ready_b, busy_b, done_b, valid_b;
  logic [31:0]  data_b;
  logic [7:0]   cd_b;
  logic [1:0]   ca_b;

  logic         start_c, ready_c, busy_c, done_c, valid_c;
  logic [15:0]  data_c;
  logic [7:0]   cd_c, ca_c;

  debug_str_serializer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_a), .busy(busy_a), .done(done_a),
    .char_valid(valid_a), .char_ready(ready_a), .char_data(cd_a), .char_addr(ca_a));

  debug_str_serializer #(.NIBBLES(8), .GROUP(2), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_b), .busy(busy_b), .done(done_b),
    .char_valid(valid_b), .char_ready(ready_b), .char_data(cd_b), .char_addr(ca_b));

  debug_str_serializer #(.NIBBLES(4), .GROUP(4), .ADDR_W(8)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(data_c), .busy(busy_c), .done(done_c),
    .char_valid(valid_c), .char_ready(ready_c), .char_data(cd_c), .char_addr(ca_c));

  int n_tests = 0;
  int n_fail  = 0;
  int qa[$];
  int qb[$];
  int qc[$];
  int dones_a = 0;
  int acc_a   = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int lc(input byte c);
`ifdef DISP_LOWERCASE_EN
    if (c >= 8'h41 && c <= 8'h46) return int'(c) + 32;
`endif
    return int'(c);
  endfunction

  // Each entry is {address, ascii}; address taken modulo the instance's address width.
  task automatic push_str(input int which, input string s, input int aw);
    for (int i = 0; i < s.len(); i++) begin
      int e;
      e = ((i % (1 << aw)) << 8) | lc(s[i]);
      case (which)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic       stall_a;
    logic [7:0] pd, pa;
    int         e;
    stall_a = 1'b0;
    pd = 8'h00;
    pa = 8'h00;
    forever begin
      @(negedge clk);
      if (done_a) dones_a++;
      if (valid_a && stall_a) begin
        check("a_stall_data", int'(cd_a), int'(pd));
        check("a_stall_addr", int'(ca_a), int'(pa));
      end
      stall_a = valid_a && !ready_a;
      pd = cd_a;
      pa = ca_a;
      if (valid_a && ready_a) begin
        check("a_q_nonempty", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check("a_char", int'(cd_a), e & 255);
          check("a_addr", int'(ca_a), e >> 8);
          acc_a++;
        end
      end
      if (valid_b && ready_b) begin
        check("b_q_nonempty", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check("b_char", int'(cd_b), e & 255);
          check("b_addr", int'(ca_b), e >> 8);
        end
      end
      if (valid_c && ready_c) begin
        check("c_q_nonempty", int'(qc.size() > 0), 1);
        if (qc.size() > 0) begin
          e = qc.pop_front();
          check("c_char", int'(cd_c), e & 255);
          check("c_addr", int'(ca_c), e >> 8);
        end
      end
    end
  end

  localparam string MAIN_STR = "01234567 89ABCDEF FEDCBA98 76543210";
  localparam logic [127:0] MAIN_DATA = 128'h0123456789ABCDEF_FEDCBA9876543210;

  initial begin : stimulus
    int n;
    int d0;
    int a0;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    data_a = '0; data_b = '0; data_c = '0;
    tick(); tick(); tick();
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_data", int'(cd_a), 0);
    check("rst_addr", int'(ca_a), 0);
    rst = 1'b0;
    tick();

    // Full-rate string with latency checks
    data_a = MAIN_DATA;
    start_a = 1'b1;
    push_str(0, MAIN_STR, 8);
    tick();
    start_a = 1'b0;
    data_a = '1;
    check("t1_first_valid", int'(valid_a), 1);
    check("t1_first_addr", int'(ca_a), 0);
    n = 0;
    while (!done_a && n < 100) begin tick(); n++; end
    check("t1_done_cycle", n, 35);
    check("t1_q_empty", qa.size(), 0);
    tick();
    check("t1_done_one_cycle", int'(done_a), 0);
    check("t1_busy_low", int'(busy_a), 0);

    // Ready toggling
    d0 = dones_a;
    data_a = MAIN_DATA;
    start_a = 1'b1;
    push_str(0, MAIN_STR, 8);
    tick();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 200) begin ready_a = ~ready_a; tick(); n++; end
    ready_a = 1'b1;
    tick(); tick();
    check("t2_done_once", dones_a - d0, 1);
    check("t2_q_empty", qa.size(), 0);

    // start held for 50 cycles with data_in changing every cycle
    d0 = dones_a;
    push_str(0, "00000000 00000000 00000000 00000000", 8);
    push_str(0, "25252525 25252525 25252525 25252525", 8);
    for (int i = 0; i < 50; i++) begin
      data_a = {16{i[7:0]}};
      start_a = 1'b1;
      tick();
    end
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 100) begin tick(); n++; end
    tick(); tick();
    check("t3_two_dones", dones_a - d0, 2);
    check("t3_q_empty", qa.size(), 0);
    check("t3_busy_low", int'(busy_a), 0);

    // Reset mid-string
    a0 = acc_a;
    data_a = MAIN_DATA;
    start_a = 1'b1;
    push_str(0, MAIN_STR, 8);
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    check("t4_accepted10", acc_a - a0, 10);
    rst = 1'b1;
    ready_a = 1'b0;
    d0 = dones_a;
    tick();
    check("t4_valid", int'(valid_a), 0);
    check("t4_busy", int'(busy_a), 0);
    check("t4_done", int'(done_a), 0);
    check("t4_data", int'(cd_a), 0);
    check("t4_addr", int'(ca_a), 0);
    rst = 1'b0;
    ready_a = 1'b1;
    qa.delete();
    repeat (5) tick();
    check("t4_no_done", dones_a - d0, 0);
    check("t4_idle", int'(busy_a), 0);
    start_a = 1'b1;
    push_str(0, MAIN_STR, 8);
    tick();
    start_a = 1'b0;
    check("t4_restart_addr", int'(ca_a), 0);
    n = 0;
    while (!done_a && n < 100) begin tick(); n++; end
    check("t4_done_cycle", n, 35);
    check("t4_q_empty", qa.size(), 0);
    tick();

    // 8 digits in groups of 2 with a 2-bit wrapping address
    data_b = 32'h00FF00FF;
    start_b = 1'b1;
    push_str(1, "00 FF 00 FF", 2);
    tick();
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 40) begin tick(); n++; end
    check("t5_done_cycle", n, 11);
    check("t5_q_empty", qb.size(), 0);
    tick();
    check("t5_busy_low", int'(busy_b), 0);

    // Group equals digit count: no separator
    data_c = 16'hBEEF;
    start_c = 1'b1;
    push_str(2, "BEEF", 8);
    tick();
    start_c = 1'b0;
    n = 0;
    while (!done_c && n < 40) begin tick(); n++; end
    check("t6_done_cycle", n, 4);
    check("t6_q_empty", qc.size(), 0);
    tick();
    check("t6_busy_low", int'(busy_c), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
